rtype_alu_sched: RTL

Two-port scheduler that time-shares a single combinational R-type execute unit between two requesters, for example the main issue slot and a secondary or debug issue path. It arbitrates incoming operations, registers the granted operation into an issue stage that drives the shared unit, and captures each result into a per-requester response register with a valid/ready handshake. It sits between issue and writeback in the core's execute stage.

---
 rtl/rtype_alu_sched.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rtype_alu_sched.sv
// rtype_alu_sched
//   Two-requester scheduler in front of one shared combinational R-type
//   execute unit. Each cycle at most one eligible request is granted. The
//   granted operation is registered into an issue stage that drives the
//   shared unit. The unit's result is then captured into the owner's
//   response register, which holds it until a valid/ready handshake.
//
// Optional feature:
//   RTYPE_SCHED_RR_EN  defined   -> round-robin tie-break through a priority pointer
//                      undefined -> fixed priority, requester 0 wins ties
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-low reset
//   req{0,1}_valid_i / _ready_o      request handshake (ready is combinational)
//   req{0,1}_op1_i/_op2_i/_inst_i/_tag_i  operation payload
//   alu_op1_o/_op2_o/_inst_o         to shared unit, zero while issue slot empty
//   alu_wdata_i, alu_we_i            result from shared unit (we=0: illegal op)
//   rsp{0,1}_valid_o / _ready_i      response handshake
//   rsp{0,1}_wdata_o/_we_o/_tag_o    registered response payload
module rtype_alu_sched #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [DATA_WIDTH-1:0] req0_op1_i,
    input  logic [DATA_WIDTH-1:0] req0_op2_i,
    input  logic [31:0]           req0_inst_i,
    input  logic [TAG_WIDTH-1:0]  req0_tag_i,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [DATA_WIDTH-1:0] req1_op1_i,
    input  logic [DATA_WIDTH-1:0] req1_op2_i,
    input  logic [31:0]           req1_inst_i,
    input  logic [TAG_WIDTH-1:0]  req1_tag_i,
    output logic [DATA_WIDTH-1:0] alu_op1_o,
    output logic [DATA_WIDTH-1:0] alu_op2_o,
    output logic [31:0]           alu_inst_o,
    input  logic [DATA_WIDTH-1:0] alu_wdata_i,
    input  logic                  alu_we_i,
    output logic                  rsp0_valid_o,
    input  logic                  rsp0_ready_i,
    output logic [DATA_WIDTH-1:0] rsp0_wdata_o,
    output logic                  rsp0_we_o,
    output logic [TAG_WIDTH-1:0]  rsp0_tag_o,
    output logic                  rsp1_valid_o,
    input  logic                  rsp1_ready_i,
    output logic [DATA_WIDTH-1:0] rsp1_wdata_o,
    output logic                  rsp1_we_o,
    output logic [TAG_WIDTH-1:0]  rsp1_tag_o
);

    logic                  busy0, busy1;
    logic                  elig0, elig1;
    logic                  grant0, grant1;
    logic                  hs0, hs1;
    logic                  tie_to1;

    logic                  iss_valid;
    logic                  iss_owner;
    logic [DATA_WIDTH-1:0] iss_op1, iss_op2;
    logic [31:0]           iss_inst;
    logic [TAG_WIDTH-1:0]  iss_tag;

    logic [DATA_WIDTH-1:0] cap_wdata;

`ifdef RTYPE_SCHED_RR_EN
    logic ptr;

    // The pointer names the loser of the last grant, so it takes the next tie.
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            ptr <= 1'b0;
        else if (grant0)
            ptr <= 1'b1;
        else if (grant1)
            ptr <= 1'b0;
    end

    assign tie_to1 = ptr;
`else
    assign tie_to1 = 1'b0;
`endif

    assign elig0 = req0_valid_i & ~busy0;
    assign elig1 = req1_valid_i & ~busy1;

    // Grants are masked while reset is asserted so ready reads 0 then.
    assign grant0 = rst_i & elig0 & (~elig1 | ~tie_to1);
    assign grant1 = rst_i & elig1 & (~elig0 |  tie_to1);

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    assign hs0 = rsp0_valid_o & rsp0_ready_i;
    assign hs1 = rsp1_valid_o & rsp1_ready_i;

    // Busy spans from grant to the response handshake. A grant and a
    // handshake for the same requester can never coincide.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            busy0 <= 1'b0;
            busy1 <= 1'b0;
        end else begin
            if (grant0)
                busy0 <= 1'b1;
            else if (hs0)
                busy0 <= 1'b0;
            if (grant1)
                busy1 <= 1'b1;
            else if (hs1)
                busy1 <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            iss_valid <= 1'b0;
            iss_owner <= 1'b0;
            iss_op1   <= '0;
            iss_op2   <= '0;
            iss_inst  <= '0;
            iss_tag   <= '0;
        end else begin
            iss_valid <= grant0 | grant1;
            if (grant0) begin
                iss_owner <= 1'b0;
                iss_op1   <= req0_op1_i;
                iss_op2   <= req0_op2_i;
                iss_inst  <= req0_inst_i;
                iss_tag   <= req0_tag_i;
            end else if (grant1) begin
                iss_owner <= 1'b1;
                iss_op1   <= req1_op1_i;
                iss_op2   <= req1_op2_i;
                iss_inst  <= req1_inst_i;
                iss_tag   <= req1_tag_i;
            end
        end
    end

    assign alu_op1_o  = iss_valid ? iss_op1  : '0;
    assign alu_op2_o  = iss_valid ? iss_op2  : '0;
    assign alu_inst_o = iss_valid ? iss_inst : '0;

    // Illegal ops still return a response, with the result forced to zero.
    assign cap_wdata = alu_we_i ? alu_wdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rsp0_valid_o <= 1'b0;
            rsp0_wdata_o <= '0;
            rsp0_we_o    <= 1'b0;
            rsp0_tag_o   <= '0;
            rsp1_valid_o <= 1'b0;
            rsp1_wdata_o <= '0;
            rsp1_we_o    <= 1'b0;
            rsp1_tag_o   <= '0;
        end else begin
            if (iss_valid && !iss_owner) begin
                rsp0_valid_o <= 1'b1;
                rsp0_wdata_o <= cap_wdata;
                rsp0_we_o    <= alu_we_i;
                rsp0_tag_o   <= iss_tag;
            end else if (hs0) begin
                rsp0_valid_o <= 1'b0;
            end
            if (iss_valid && iss_owner) begin
                rsp1_valid_o <= 1'b1;
                rsp1_wdata_o <= cap_wdata;
                rsp1_we_o    <= alu_we_i;
                rsp1_tag_o   <= iss_tag;
            end else if (hs1) begin
                rsp1_valid_o <= 1'b0;
            end
        end
    end

endmodule
